// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers and pipeline stall generation.
// Uses one shift-add or restoring-divide step per cycle on magnitudes, then fixes signs.
module muldiv_ctrl #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] srca,
  input  logic [n-1:0] srcb,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [n-1:0] wdata,
  input  logic         rdhilo,
  output logic         busy,
  output logic         done,
  output logic         stall,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [n-1:0]   accHi_q, accHi_d;
  logic [n-1:0]   accLo_q, accLo_d;
  logic [n-1:0]   opnd_q, opnd_d;
  logic [n-1:0]   hi_q, hi_d;
  logic [n-1:0]   lo_q, lo_d;
  logic           isDiv_q, isDiv_d;
  logic           negQ_q, negQ_d;
  logic           negR_q, negR_d;

  logic           signedOp;
  logic [n-1:0]   absA, absB;
  logic [n:0]     mulSum;
  logic [n:0]     shifted;
  logic [2*n-1:0] prod;

  always_comb begin
    signedOp = ~op[0];
    absA     = (signedOp && srca[n-1]) ? -srca : srca;
    absB     = (signedOp && srcb[n-1]) ? -srcb : srcb;
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
    shifted  = {accHi_q, accLo_q[n-1]};
    prod     = {accHi_q, accLo_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accHi_d = accHi_q;
    accLo_d = accLo_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    isDiv_d = isDiv_q;
    negQ_d  = negQ_q;
    negR_d  = negR_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          isDiv_d = op[1];
          accHi_d = '0;
          accLo_d = op[1] ? absA : absB;
          opnd_d  = op[1] ? absB : absA;
          // A zero divisor must leave the all-ones quotient un-negated.
          negQ_d  = signedOp & (srca[n-1] ^ srcb[n-1]) & (~op[1] | (|srcb));
          negR_d  = signedOp & op[1] & srca[n-1];
        end
      end

      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (isDiv_q) begin
          if (shifted >= {1'b0, opnd_q}) begin
            accHi_d = shifted[n-1:0] - opnd_q;
            accLo_d = {accLo_q[n-2:0], 1'b1};
          end else begin
            accHi_d = shifted[n-1:0];
            accLo_d = {accLo_q[n-2:0], 1'b0};
          end
        end else begin
          {accHi_d, accLo_d} = {mulSum, accLo_q[n-1:1]};
        end
        if (cnt_q == CW'(n - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end

      FIX: begin
        state_d = DONE;
        if (isDiv_q) begin
          lo_d = negQ_q ? -accLo_q : accLo_q;
          hi_d = negR_q ? -accHi_q : accHi_q;
        end else begin
          {hi_d, lo_d} = negQ_q ? -prod : prod;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      accHi_q <= '0;
      accLo_q <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      isDiv_q <= 1'b0;
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      accHi_q <= accHi_d;
      accLo_q <= accLo_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      isDiv_q <= isDiv_d;
      negQ_q  <= negQ_d;
      negR_q  <= negR_d;
    end
  end

  assign busy  = (state_q == CALC) || (state_q == FIX);
  assign done  = (state_q == DONE);
  assign stall = busy & (rdhilo | start | mthi | mtlo);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
